// File: rtl/cipher_pkg.sv
// Shared types and constants for the iterative block cipher engine:
// mode values, FSM states and the three-phase round encoding.
package cipher_pkg;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Phase index within a round.
  // Encrypt order: ROT, MIX, WHT. Decrypt order: UNWHT, UNMIX, UNROT.
  localparam logic [1:0] PH_FIRST  = 2'd0;
  localparam logic [1:0] PH_SECOND = 2'd1;
  localparam logic [1:0] PH_LAST   = 2'd2;

endpackage

// File: rtl/block_cipher_engine_if.sv
// Request/result bus of the cipher engine. Both directions use valid/ready:
// a transfer happens on a rising edge where valid and ready are both high.
interface block_cipher_engine_if #(
  parameter int NWORDS = 4,
  parameter int WORD_W = 64
);
  import cipher_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic                     mode;
  logic [NWORDS*WORD_W-1:0] data_in;
  logic [WORD_W-1:0]        key1;
  logic [WORD_W-1:0]        key2;
  logic                     out_valid;
  logic                     out_ready;
  logic [NWORDS*WORD_W-1:0] data_out;
  logic                     busy;
  state_t                   state;

  modport master (
    output in_valid, mode, data_in, key1, key2, out_ready,
    input  in_ready, out_valid, data_out, busy, state
  );

  modport slave (
    input  in_valid, mode, data_in, key1, key2, out_ready,
    output in_ready, out_valid, data_out, busy, state
  );
endinterface

// File: rtl/cipher_phase.sv
// Combinational single-phase transform of the whole block. The phase
// index selects ROT/MIX/WHT when encrypting and UNWHT/UNMIX/UNROT when decrypting.
module cipher_phase
  import cipher_pkg::*;
#(
  parameter int NWORDS = 4,
  parameter int WORD_W = 64
) (
  input  logic [NWORDS*WORD_W-1:0] blk_in,
  input  logic [WORD_W-1:0]        key1,
  input  logic [WORD_W-1:0]        key2,
  input  logic                     mode,
  input  logic [1:0]               phase,
  output logic [NWORDS*WORD_W-1:0] blk_out
);

  always_comb begin
    blk_out = blk_in;
    case ({mode, phase})
      {MODE_ENC, PH_FIRST}: begin
        for (int i = 0; i < NWORDS; i++)
          blk_out[i*WORD_W +: WORD_W] =
            {blk_in[i*WORD_W +: WORD_W-1], blk_in[i*WORD_W + WORD_W-1]};
      end
      {MODE_ENC, PH_SECOND}: begin
        for (int i = 0; i < NWORDS-1; i++)
          blk_out[(i+1)*WORD_W +: WORD_W] = blk_in[i*WORD_W +: WORD_W];
        blk_out[0 +: WORD_W] = blk_in[(NWORDS-1)*WORD_W +: WORD_W] ^ key1;
      end
      // Whitening is its own inverse, so both directions share it.
      {MODE_ENC, PH_LAST}, {MODE_DEC, PH_FIRST}: begin
        for (int i = 0; i < NWORDS; i++)
          blk_out[i*WORD_W +: WORD_W] = blk_in[i*WORD_W +: WORD_W] ^ key2;
      end
      {MODE_DEC, PH_SECOND}: begin
        for (int i = 0; i < NWORDS-1; i++)
          blk_out[i*WORD_W +: WORD_W] = blk_in[(i+1)*WORD_W +: WORD_W];
        blk_out[(NWORDS-1)*WORD_W +: WORD_W] = blk_in[0 +: WORD_W] ^ key1;
      end
      {MODE_DEC, PH_LAST}: begin
        for (int i = 0; i < NWORDS; i++)
          blk_out[i*WORD_W +: WORD_W] =
            {blk_in[i*WORD_W], blk_in[i*WORD_W+1 +: WORD_W-1]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/block_cipher_engine.sv
// Iterative handshaked cipher engine: one phase per clock, three phases per
// round, result held in DONE until the consumer takes it.
module block_cipher_engine
  import cipher_pkg::*;
#(
  parameter int NWORDS = 4,
  parameter int WORD_W = 64,
  parameter int ROUNDS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  block_cipher_engine_if.slave  bus
);

  localparam int BW = NWORDS * WORD_W;
  localparam int RW = $clog2(ROUNDS + 1);

  state_t          state_q, state_d;
  logic [BW-1:0]   blk_q, blk_nxt, data_out_q;
  logic [WORD_W-1:0] key1_q, key2_q;
  logic            mode_q;
  logic [1:0]      phase_q;
  logic [RW-1:0]   round_q;
  logic            last_phase;
  logic            accept;
  logic            in_ready_o, out_valid_o, busy_o;

  cipher_phase #(.NWORDS(NWORDS), .WORD_W(WORD_W)) u_phase (
    .blk_in  (blk_q),
    .key1    (key1_q),
    .key2    (key2_q),
    .mode    (mode_q),
    .phase   (phase_q),
    .blk_out (blk_nxt)
  );

  assign last_phase = (phase_q == PH_LAST) && (round_q == RW'(ROUNDS - 1));
  assign accept     = (state_q == IDLE) && bus.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last_phase)    state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
    busy_o      = (state_q == RUN);
  end

  // Operands are captured only on accept, so input changes during RUN are inert.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q      <= '0;
      data_out_q <= '0;
      key1_q     <= '0;
      key2_q     <= '0;
      mode_q     <= MODE_ENC;
      phase_q    <= PH_FIRST;
      round_q    <= '0;
    end else if (accept) begin
      blk_q   <= bus.data_in;
      key1_q  <= bus.key1;
      key2_q  <= bus.key2;
      mode_q  <= bus.mode;
      phase_q <= PH_FIRST;
      round_q <= '0;
    end else if (state_q == RUN) begin
      blk_q <= blk_nxt;
      if (phase_q == PH_LAST) begin
        phase_q <= PH_FIRST;
        round_q <= round_q + RW'(1);
      end else begin
        phase_q <= phase_q + 2'd1;
      end
      if (last_phase) data_out_q <= blk_nxt;
    end
  end

  assign bus.in_ready  = in_ready_o;
  assign bus.out_valid = out_valid_o;
  assign bus.busy      = busy_o;
  assign bus.data_out  = data_out_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_block_cipher_engine.sv
// Bench for block_cipher_engine: three instances (4x64 R1, 4x64 R4, 8x32 R3)
// compared against a word-array reference model.
module tb_block_cipher_engine;
  import cipher_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid_v [3];
  logic         out_ready_v[3];
  logic         mode_v;
  logic [255:0] data_v;
  logic [63:0]  key1_v, key2_v;
  logic         in_ready_w [3];
  logic         out_valid_w[3];
  logic         busy_w     [3];
  logic [255:0] data_out_w [3];

  int checks = 0;
  int errors = 0;
  int cfg_n[3] = '{4, 4, 8};
  int cfg_w[3] = '{64, 64, 32};
  int cfg_r[3] = '{1, 4, 3};

  block_cipher_engine_if #(.NWORDS(4), .WORD_W(64)) if_a ();
  block_cipher_engine_if #(.NWORDS(4), .WORD_W(64)) if_b ();
  block_cipher_engine_if #(.NWORDS(8), .WORD_W(32)) if_c ();

  block_cipher_engine #(.NWORDS(4), .WORD_W(64), .ROUNDS(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  block_cipher_engine #(.NWORDS(4), .WORD_W(64), .ROUNDS(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  block_cipher_engine #(.NWORDS(8), .WORD_W(32), .ROUNDS(3)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  assign if_a.in_valid = in_valid_v[0];  assign if_a.out_ready = out_ready_v[0];
  assign if_b.in_valid = in_valid_v[1];  assign if_b.out_ready = out_ready_v[1];
  assign if_c.in_valid = in_valid_v[2];  assign if_c.out_ready = out_ready_v[2];
  assign if_a.mode = mode_v;  assign if_b.mode = mode_v;  assign if_c.mode = mode_v;
  assign if_a.data_in = data_v;  assign if_b.data_in = data_v;  assign if_c.data_in = data_v;
  assign if_a.key1 = key1_v;  assign if_b.key1 = key1_v;  assign if_c.key1 = key1_v[31:0];
  assign if_a.key2 = key2_v;  assign if_b.key2 = key2_v;  assign if_c.key2 = key2_v[31:0];

  assign in_ready_w[0] = if_a.in_ready;  assign out_valid_w[0] = if_a.out_valid;
  assign in_ready_w[1] = if_b.in_ready;  assign out_valid_w[1] = if_b.out_valid;
  assign in_ready_w[2] = if_c.in_ready;  assign out_valid_w[2] = if_c.out_valid;
  assign busy_w[0] = if_a.busy;  assign busy_w[1] = if_b.busy;  assign busy_w[2] = if_c.busy;
  assign data_out_w[0] = if_a.data_out;
  assign data_out_w[1] = if_b.data_out;
  assign data_out_w[2] = if_c.data_out;

  // Reference model: block as an array of n words of w bits.
  function automatic logic [255:0] model(input logic m, input logic [255:0] x,
                                         input logic [63:0] k1, input logic [63:0] k2,
                                         input int n, input int w, input int rounds);
    logic [63:0]  v[8];
    logic [63:0]  mask, tmp, a1, a2;
    logic [255:0] r;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a1 = k1 & mask;
    a2 = k2 & mask;
    for (int i = 0; i < n; i++) v[i] = 64'(x >> (i * w)) & mask;
    for (int rd = 0; rd < rounds; rd++) begin
      if (m == MODE_ENC) begin
        for (int i = 0; i < n; i++) v[i] = ((v[i] << 1) | (v[i] >> (w - 1))) & mask;
        tmp = v[n-1];
        for (int i = n - 1; i > 0; i--) v[i] = v[i-1];
        v[0] = tmp ^ a1;
        for (int i = 0; i < n; i++) v[i] = v[i] ^ a2;
      end else begin
        for (int i = 0; i < n; i++) v[i] = v[i] ^ a2;
        tmp = v[0] ^ a1;
        for (int i = 0; i < n - 1; i++) v[i] = v[i+1];
        v[n-1] = tmp;
        for (int i = 0; i < n; i++) v[i] = ((v[i] >> 1) | (v[i] << (w - 1))) & mask;
      end
    end
    r = '0;
    for (int i = 0; i < n; i++) r = r | (256'(v[i]) << (i * w));
    return r;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Presents a request, waits for accept, then scrambles the shared inputs.
  task automatic start(input int s, input logic m, input logic [255:0] d,
                       input logic [63:0] k1, input logic [63:0] k2);
    int n = 0;
    mode_v = m; data_v = d; key1_v = k1; key2_v = k2;
    while (!in_ready_w[s] && n < 50) begin @(posedge clk); #1; n++; end
    in_valid_v[s] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[s] = 1'b0;
    mode_v = ~m; data_v = rand256(); key1_v = {$urandom, $urandom}; key2_v = {$urandom, $urandom};
  endtask

  task automatic wait_result(input int s, input int budget, output int lat, output logic [255:0] res);
    lat = 0;
    while (!out_valid_w[s] && lat < budget) begin @(posedge clk); #1; lat++; end
    res = data_out_w[s];
  endtask

  task automatic release_out(input int s);
    out_ready_v[s] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[s] = 1'b0;
  endtask

  task automatic transact(input int s, input logic m, input logic [255:0] d,
                          input logic [63:0] k1, input logic [63:0] k2,
                          output logic [255:0] res, output int lat);
    start(s, m, d, k1, k2);
    wait_result(s, 60, lat, res);
    release_out(s);
  endtask

  logic [255:0] res, res2, x, exp_v, held;
  logic [63:0]  k1, k2;
  int           lat;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b0; end
    mode_v = MODE_ENC; data_v = '0; key1_v = '0; key2_v = '0;
    #2;
    check("rst_in_ready", 256'(in_ready_w[0]), 256'(1));
    check("rst_out_valid", 256'(out_valid_w[0]), 256'(0));
    check("rst_busy", 256'(busy_w[0]), 256'(0));
    check("rst_data_out", data_out_w[0], '0);
    // Request pending across reset release must wait for a clocked edge.
    in_valid_v[0] = 1'b1;
    @(posedge clk); #3; rst_n = 1'b1;
    check("no_accept_in_reset", 256'(busy_w[0]), 256'(0));
    in_valid_v[0] = 1'b0;
    @(posedge clk); #1;

    // Single-bit encrypt / decrypt.
    x = 256'd1;
    transact(0, MODE_ENC, x, 64'd0, 64'd0, res, lat);
    check("enc_bit_data", res, 256'd1 << 65);
    check("enc_bit_lat", 256'(lat), 256'(3));
    check("enc_bit_ready_after", 256'(in_ready_w[0]), 256'(1));
    transact(0, MODE_DEC, 256'd1 << 65, 64'd0, 64'd0, res, lat);
    check("dec_bit_data", res, 256'd1);

    // Whitening with all-ones key2.
    transact(0, MODE_ENC, '0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, res, lat);
    check("enc_white_data", res, {256{1'b1}});

    // Rotate/mix wrap cancelled by key1.
    x = 256'h8000_0000_0000_0000 << 192;
    transact(0, MODE_ENC, x, 64'd1, 64'd0, res, lat);
    check("enc_wrap_data", res, '0);
    transact(0, MODE_DEC, '0, 64'd1, 64'd0, res, lat);
    check("dec_wrap_data", res, x);

    // Backpressure with ignored request pulses.
    x = rand256(); k1 = {$urandom, $urandom}; k2 = {$urandom, $urandom};
    start(0, MODE_ENC, x, k1, k2);
    wait_result(0, 60, lat, held);
    check("bp_data", held, model(MODE_ENC, x, k1, k2, 4, 64, 1));
    for (int c = 0; c < 5; c++) begin
      in_valid_v[0] = c[0];
      data_v = rand256();
      @(posedge clk); #1;
      check("bp_out_valid", 256'(out_valid_w[0]), 256'(1));
      check("bp_data_stable", data_out_w[0], held);
      check("bp_in_ready", 256'(in_ready_w[0]), 256'(0));
    end
    in_valid_v[0] = 1'b0;
    release_out(0);
    check("bp_ready_after", 256'(in_ready_w[0]), 256'(1));
    check("bp_no_reaccept", 256'(busy_w[0]), 256'(0));
    @(posedge clk); #1;
    check("bp_no_phantom", 256'(out_valid_w[0]), 256'(0));

    // Reset in the middle of a 4-round operation.
    start(1, MODE_ENC, rand256(), {$urandom, $urandom}, {$urandom, $urandom});
    repeat (4) begin @(posedge clk); #1; end
    check("mid_busy", 256'(busy_w[1]), 256'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 256'(out_valid_w[1]), 256'(0));
    check("mid_rst_in_ready", 256'(in_ready_w[1]), 256'(1));
    check("mid_rst_data_out", data_out_w[1], '0);
    check("mid_rst_busy", 256'(busy_w[1]), 256'(0));
    #2; rst_n = 1'b1;
    @(posedge clk); #1;
    x = rand256(); k1 = {$urandom, $urandom}; k2 = {$urandom, $urandom};
    transact(1, MODE_ENC, x, k1, k2, res, lat);
    check("r4_data", res, model(MODE_ENC, x, k1, k2, 4, 64, 4));
    check("r4_lat", 256'(lat), 256'(12));

    // Random round trips on the 8x32, 3-round instance.
    for (int t = 0; t < 200; t++) begin
      x = rand256(); k1 = {32'd0, $urandom}; k2 = {32'd0, $urandom};
      exp_v = model(MODE_ENC, x, k1, k2, cfg_n[2], cfg_w[2], cfg_r[2]);
      transact(2, MODE_ENC, x, k1, k2, res, lat);
      check("rnd_enc_data", res, exp_v);
      check("rnd_enc_lat", 256'(lat), 256'(9));
      transact(2, MODE_DEC, res, k1, k2, res2, lat);
      check("rnd_roundtrip", res2, x);
      check("rnd_dec_lat", 256'(lat), 256'(9));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
